cluster_frame_tx: RTL and testbench

- Transmit side of the per-BX cluster count interface.
- Takes one snapshot per bunch crossing: a cluster count, an overflow flag and up to NCLUSTERS packed cluster words.
- Serialises the snapshot onto a 16-bit valid/ready link as one header word followed by N cluster words.
- Sits directly downstream of the cluster counter and packer, in the clock4x domain, and feeds the optical-link framer.

---
 rtl/cluster_pkg.sv | 39 +++
 rtl/cluster_word_mux.sv | 42 ++++
 rtl/cluster_frame_tx.sv | 178 +++++++++++++++++
 tb/tb_cluster_frame_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cluster_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cluster_pkg
// Description : Shared constants, header field positions and FSM state
//               encoding for the per-BX cluster frame transmitter.
// Revision    : 1.0  initial release
// ============================================================================
package cluster_pkg;

  // Geometry of one snapshot
  localparam int NCLUSTERS = 8;   // max cluster words per frame
  localparam int CLW       = 14;  // 11-bit strip address + 3-bit size
  localparam int SEQW      = 9;   // frame sequence counter width

  // Link word markers (top two bits of every 16-bit word)
  localparam logic [1:0] HDR_MARKER  = 2'b11;
  localparam logic [1:0] DATA_MARKER = 2'b00;

  // Header field bit positions
  localparam int HDR_MARK_MSB = 15;
  localparam int HDR_MARK_LSB = 14;
  localparam int HDR_OVF_BIT  = 13;
  localparam int HDR_N_MSB    = 12;
  localparam int HDR_N_LSB    = 9;
  localparam int HDR_SEQ_MSB  = 8;
  localparam int HDR_SEQ_LSB  = 0;

  // Width of the emitted-word count carried in the header
  localparam int NW = HDR_N_MSB - HDR_N_LSB + 1;

  // Transmit FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage : cluster_pkg
`default_nettype wire

// File: rtl/cluster_word_mux.sv
`default_nettype none
// ============================================================================
// Module      : cluster_word_mux
// Description : Combinational selection of one cluster word out of the
//               registered snapshot vector. Out-of-range selects return 0.
// Ports       : clusters  in  NCLUSTERS*CLW  packed words, index 0 in LSBs
//               sel       in  4              word index
//               word      out CLW            selected cluster word
// Revision    : 1.0  initial release
// ============================================================================
module cluster_word_mux #(
  parameter int NCLUSTERS = cluster_pkg::NCLUSTERS,
  parameter int CLW       = cluster_pkg::CLW
) (
  input  logic [NCLUSTERS*CLW-1:0] clusters,
  input  logic [3:0]               sel,
  output logic [CLW-1:0]           word
);

  logic [CLW-1:0] w_words [NCLUSTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NCLUSTERS; gi++) begin : g_unpack
      assign w_words[gi] = clusters[gi*CLW +: CLW];
    end
  endgenerate

  // Compare-and-select rather than a direct array index so that a select
  // one past the last cluster (seen while the final word is on the link)
  // yields a clean zero instead of an out-of-range read.
  always_comb begin
    word = '0;
    for (int i = 0; i < NCLUSTERS; i++) begin
      if (sel == 4'(i)) begin
        word = w_words[i];
      end
    end
  end

endmodule : cluster_word_mux
`default_nettype wire

// File: rtl/cluster_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : cluster_frame_tx
// Description : Transmit side of the per-BX cluster count interface. Takes
//               one snapshot per bunch crossing and serialises it onto a
//               16-bit valid/ready link as a header word followed by
//               min(cnt, NCLUSTERS) cluster words.
// Ports       : clock4x       in   1   sole clock, rising edge
//               reset         in   1   asynchronous, active-high
//               snap_valid_i  in   1   snapshot strobe
//               cnt_i         in   8   cluster count
//               overflow_i    in   1   counter overflow flag
//               clusters_i    in   NCLUSTERS*CLW  cluster words, 0 in LSBs
//               tx_data_o     out  16  link word
//               tx_valid_o    out  1   link word valid
//               tx_ready_i    in   1   link ready
//               busy_o        out  1   frame in progress
//               drop_cnt_o    out  8   saturating dropped-snapshot count
// Revision    : 1.0  initial release
// ============================================================================
module cluster_frame_tx #(
  parameter int NCLUSTERS = cluster_pkg::NCLUSTERS,
  parameter int CLW       = cluster_pkg::CLW,
  parameter int SEQW      = cluster_pkg::SEQW
) (
  input  logic                     clock4x,
  input  logic                     reset,
  input  logic                     snap_valid_i,
  input  logic [7:0]               cnt_i,
  input  logic                     overflow_i,
  input  logic [NCLUSTERS*CLW-1:0] clusters_i,
  output logic [15:0]              tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic                     busy_o,
  output logic [7:0]               drop_cnt_o
);

  import cluster_pkg::*;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t                   r_state;
  logic [NW-1:0]            r_n_emit;    // words to emit after the header
  logic [3:0]               r_idx;       // index of the cluster on the link
  logic [NCLUSTERS*CLW-1:0] r_clusters;  // snapshot of the cluster words
  logic [SEQW-1:0]          r_seq;

  // --------------------------------------------------------------------------
  // Handshake / acceptance decode
  // --------------------------------------------------------------------------
  logic            w_hs;
  logic            w_last;
  logic            w_accept;
  logic            w_drop;
  logic            w_hdr_hs;
  logic [SEQW-1:0] w_seq_next;
  logic            w_clamp;
  logic            w_in_ovf;
  logic [NW-1:0]   w_in_n;
  logic [15:0]     w_hdr_word;
  logic [3:0]      w_sel;
  logic [CLW-1:0]  w_cl_word;
  logic [15:0]     w_data_word;

  assign w_hs = tx_valid_o & tx_ready_i;

  // Last word of the frame is either a header of an empty frame or the
  // final cluster word.
  assign w_last = w_hs &
                  (((r_state == ST_HDR)  && (r_n_emit == '0)) ||
                   ((r_state == ST_DATA) && (r_idx == (r_n_emit - 4'd1))));

  assign w_accept = snap_valid_i & ((r_state == ST_IDLE) | w_last);
  assign w_drop   = snap_valid_i & ~w_accept;

  // The sequence counter advances on the header handshake. A back-to-back
  // accept in that same cycle (header-only frame) must already see the
  // advanced value, hence the header is built from the next value.
  assign w_hdr_hs   = w_hs & (r_state == ST_HDR);
  assign w_seq_next = r_seq + {{(SEQW-1){1'b0}}, w_hdr_hs};

  assign w_clamp    = (cnt_i > 8'(NCLUSTERS));
  assign w_in_ovf   = overflow_i | w_clamp;
  assign w_in_n     = w_clamp ? NW'(NCLUSTERS) : cnt_i[NW-1:0];
  assign w_hdr_word = {HDR_MARKER, w_in_ovf, w_in_n, w_seq_next};

  // Select the word that goes on the link after the current handshake:
  // cluster 0 when leaving the header, otherwise the next cluster.
  assign w_sel       = (r_state == ST_HDR) ? 4'd0 : (r_idx + 4'd1);
  assign w_data_word = {DATA_MARKER, w_cl_word};

  cluster_word_mux #(
    .NCLUSTERS (NCLUSTERS),
    .CLW       (CLW)
  ) u_word_mux (
    .clusters (r_clusters),
    .sel      (w_sel),
    .word     (w_cl_word)
  );

  // --------------------------------------------------------------------------
  // Transmit FSM with registered link outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_n_emit   <= '0;
      r_idx      <= '0;
      r_clusters <= '0;
      r_seq      <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      r_seq <= w_seq_next;

      if (w_drop && (drop_cnt_o != 8'hFF)) begin
        drop_cnt_o <= drop_cnt_o + 8'd1;
      end

      if (w_accept) begin
        // New frame: header goes out next cycle, covers both the idle and
        // the back-to-back case.
        r_state    <= ST_HDR;
        r_n_emit   <= w_in_n;
        r_clusters <= clusters_i;
        r_idx      <= '0;
        tx_data_o  <= w_hdr_word;
        tx_valid_o <= 1'b1;
        busy_o     <= 1'b1;
      end else begin
        case (r_state)
          ST_HDR: begin
            if (w_hs) begin
              if (r_n_emit == '0) begin
                r_state    <= ST_IDLE;
                tx_data_o  <= '0;
                tx_valid_o <= 1'b0;
                busy_o     <= 1'b0;
              end else begin
                r_state   <= ST_DATA;
                r_idx     <= '0;
                tx_data_o <= w_data_word;
              end
            end
          end
          ST_DATA: begin
            if (w_hs) begin
              if (w_last) begin
                r_state    <= ST_IDLE;
                tx_data_o  <= '0;
                tx_valid_o <= 1'b0;
                busy_o     <= 1'b0;
              end else begin
                r_idx     <= r_idx + 4'd1;
                tx_data_o <= w_data_word;
              end
            end
          end
          ST_IDLE: begin
            // Link ready is ignored while nothing is offered.
          end
          default: begin
            r_state    <= ST_IDLE;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : cluster_frame_tx
`default_nettype wire

// File: tb/tb_cluster_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cluster_frame_tx
// Description : Self-checking bench for cluster_frame_tx. A queue holds the
//               link words each accepted snapshot must produce; every cycle
//               the link outputs are compared with the queue head.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cluster_frame_tx;

  localparam int NCL = 8;
  localparam int CW  = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              snap_valid_i;
  logic [7:0]        cnt_i;
  logic              overflow_i;
  logic [NCL*CW-1:0] clusters_i;
  logic [15:0]       tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic              busy_o;
  logic [7:0]        drop_cnt_o;

  cluster_frame_tx u_dut (
    .clock4x      (clk),
    .reset        (rst),
    .snap_valid_i (snap_valid_i),
    .cnt_i        (cnt_i),
    .overflow_i   (overflow_i),
    .clusters_i   (clusters_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .busy_o       (busy_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] exp_q[$];
  int          m_seq;
  int          m_drops;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected words for one accepted snapshot
  task automatic model_frame(input int cnt, input bit ovf, input logic [NCL*CW-1:0] cl);
    int n;
    int flag;
    int hdr;
    n    = (cnt > NCL) ? NCL : cnt;
    flag = (ovf || cnt > NCL) ? 1 : 0;
    hdr  = 'hC000 + flag * 8192 + n * 512 + m_seq;
    exp_q.push_back(16'(hdr));
    for (int k = 0; k < n; k++) exp_q.push_back({2'b00, cl[k*CW +: CW]});
    m_seq = (m_seq + 1) % 512;
  endtask

  task automatic compare_outputs();
    bit act;
    act = (exp_q.size() > 0);
    chk("valid", {31'd0, tx_valid_o}, {31'd0, act});
    chk("busy",  {31'd0, busy_o},     {31'd0, act});
    if (act) chk("data", {16'd0, tx_data_o}, {16'd0, exp_q[0]});
    chk("drop", {24'd0, drop_cnt_o}, 32'(m_drops));
  endtask

  // One clock cycle: called at a negedge, drives inputs, updates the model
  // for the coming rising edge, then checks just after the edge.
  task automatic step(input bit sv, input int cnt, input bit ovf,
                      input logic [NCL*CW-1:0] cl, input bit rdy);
    snap_valid_i = sv;
    cnt_i        = 8'(cnt);
    overflow_i   = ovf;
    clusters_i   = cl;
    tx_ready_i   = rdy;
    if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
    // Queue empty now means the link was idle or the last word just went.
    if (sv) begin
      if (exp_q.size() == 0) model_frame(cnt, ovf, cl);
      else if (m_drops < 255) m_drops++;
    end
    @(posedge clk);
    #1;
    compare_outputs();
    @(negedge clk);
  endtask

  function automatic logic [NCL*CW-1:0] rand_clusters();
    logic [NCL*CW-1:0] v;
    for (int k = 0; k < NCL; k++) v[k*CW +: CW] = 14'($urandom);
    return v;
  endfunction

  logic [NCL*CW-1:0] cl3;
  logic [NCL*CW-1:0] clr;

  initial begin
    rst = 1'b1; snap_valid_i = 0; cnt_i = 0; overflow_i = 0;
    clusters_i = '0; tx_ready_i = 0;
    exp_q.delete(); m_seq = 0; m_drops = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, tx_valid_o}, 32'd0);
    chk("rst_data",  {16'd0, tx_data_o},  32'd0);
    chk("rst_busy",  {31'd0, busy_o},     32'd0);
    chk("rst_drop",  {24'd0, drop_cnt_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1. single frame
    cl3 = '0;
    cl3[0*CW +: CW] = 14'h0101;
    cl3[1*CW +: CW] = 14'h0202;
    cl3[2*CW +: CW] = 14'h0303;
    step(1, 3, 0, cl3, 1);
    chk("t1_hdr", {16'd0, tx_data_o}, 32'h0000C600);
    repeat (4) step(0, 0, 0, '0, 1);
    chk("t1_idle", {31'd0, tx_valid_o}, 32'd0);

    // 2. zero clusters, then the next frame carries the next sequence
    step(1, 0, 0, '0, 1);
    chk("t2_hdr", {16'd0, tx_data_o}, 32'h0000C001);
    step(0, 0, 0, '0, 1);
    step(1, 0, 0, '0, 1);
    chk("t2_seq", {16'd0, tx_data_o}, 32'h0000C002);
    step(0, 0, 0, '0, 1);

    // 3. overflow clamp
    clr = rand_clusters();
    step(1, 20, 0, clr, 1);
    chk("t3_hdr", {16'd0, tx_data_o}, 32'h0000F003);
    repeat (10) step(0, 0, 0, '0, 1);

    // 4. backpressure on data word 1
    clr = rand_clusters();
    step(1, 4, 0, clr, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    repeat (5) step(0, 0, 0, '0, 0);
    repeat (5) step(0, 0, 0, '0, 1);

    // 5. drop mid-frame, then back-to-back accept on the last handshake
    step(1, 3, 1, cl3, 1);
    step(0, 0, 0, '0, 1);
    step(1, 5, 0, clr, 1);
    chk("t5_drop", {24'd0, drop_cnt_o}, 32'd1);
    step(0, 0, 0, '0, 1);
    step(1, 2, 0, clr, 1);
    chk("t5_b2b", {30'd0, tx_data_o[15:14]}, 32'd3);
    repeat (5) step(0, 0, 0, '0, 1);

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      int cnt;
      cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 10));
      step($urandom_range(0, 5) == 0, cnt, 1'($urandom), rand_clusters(),
           $urandom_range(0, 3) != 0);
    end
    repeat (20) step(0, 0, 0, '0, 1);

    // Drop counter saturation against a stalled frame
    step(1, 8, 0, rand_clusters(), 1);
    for (int c = 0; c < 300; c++) step(1, 1, 0, '0, 0);
    chk("sat_drop", {24'd0, drop_cnt_o}, 32'd255);
    repeat (12) step(0, 0, 0, '0, 1);

    // 6. asynchronous reset mid-DATA
    step(1, 6, 0, rand_clusters(), 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    snap_valid_i = 0;
    tx_ready_i   = 0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, tx_valid_o}, 32'd0);
    chk("arst_data",  {16'd0, tx_data_o},  32'd0);
    chk("arst_busy",  {31'd0, busy_o},     32'd0);
    chk("arst_drop",  {24'd0, drop_cnt_o}, 32'd0);
    exp_q.delete(); m_seq = 0; m_drops = 0;
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, '0, 1);
    chk("arst_noresume", {31'd0, tx_valid_o}, 32'd0);

    // 600 header-only frames streamed back-to-back
    for (int f = 0; f < 600; f++) begin
      step(1, 0, 0, '0, 1);
      chk("seq_wrap", {23'd0, tx_data_o[8:0]}, 32'(f % 512));
    end
    step(0, 0, 0, '0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cluster_frame_tx
`default_nettype wire
